// File: rtl/key_pkg.sv
// Shared types and 50 MHz timing defaults for the board key conditioner.
package key_pkg;

    localparam int DEF_DEBOUNCE_CYCLES = 1_000_000;
    localparam int DEF_REPEAT_DELAY    = 25_000_000;
    localparam int DEF_REPEAT_RATE     = 10_000_000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DELAY,
        ST_REPEAT
    } step_state_e;

    typedef struct packed {
        logic db;
        logic press;
        logic rel;
    } key_evt_t;

endpackage

// File: rtl/key_debounce.sv
// Synchronises and debounces one active-low key.
// Emits registered one-cycle press/release strobes.
module key_debounce
    import key_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     key,
    output key_evt_t evt
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_END = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic          db;
    logic          press;
    logic          rel;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            db    <= 1'b1;
            cnt   <= '0;
            press <= 1'b0;
            rel   <= 1'b0;
        end else begin
            sync1 <= key;
            sync2 <= sync1;
            press <= 1'b0;
            rel   <= 1'b0;
            if (sync2 != db) begin
                if (cnt == CNT_END) begin
                    db    <= sync2;
                    cnt   <= '0;
                    press <= ~sync2;
                    rel   <= sync2;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

    assign evt = '{db: db, press: press, rel: rel};

endmodule

// File: rtl/key_step_conditioner.sv
// Turns KEY_STEP/KEY_DIR into clean step/direction events
// for the LED ring shifter, with optional step auto-repeat.
module key_step_conditioner
    import key_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_RATE     = DEF_REPEAT_RATE
) (
    input  logic CLOCK_50,
    input  logic RESET_N,
    input  logic KEY_STEP,
    input  logic KEY_DIR,
    output logic step_pulse,
    output logic dir_pulse,
    output logic dir,
    output logic step_held
);

    localparam int DW   = $clog2(REPEAT_DELAY) + 1;
    localparam int RW   = $clog2(REPEAT_RATE) + 1;
    localparam int RC_W = (DW > RW) ? DW : RW;

    localparam bit RPT_EN = (REPEAT_DELAY > 0);
    localparam logic [RC_W-1:0] DLY_END =
        RC_W'(RPT_EN ? REPEAT_DELAY - 1 : 0);
    localparam logic [RC_W-1:0] RATE_END = RC_W'(REPEAT_RATE - 1);

    key_evt_t step_evt;
    key_evt_t dir_evt;

    step_state_e     state_q;
    step_state_e     state_d;
    logic [RC_W-1:0] rc_q;
    logic [RC_W-1:0] rc_d;
    logic            step_d;

    logic unused_dir_evt;

    key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_step_db (
        .clk  (CLOCK_50),
        .rst_n(RESET_N),
        .key  (KEY_STEP),
        .evt  (step_evt)
    );

    key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_dir_db (
        .clk  (CLOCK_50),
        .rst_n(RESET_N),
        .key  (KEY_DIR),
        .evt  (dir_evt)
    );

    // Only the press edge matters for the direction toggle.
    assign unused_dir_evt = ^{dir_evt.db, dir_evt.rel};

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= ST_IDLE;
            rc_q    <= '0;
        end else begin
            state_q <= state_d;
            rc_q    <= rc_d;
        end
    end

    // Release wins over any simultaneous count expiry.
    always_comb begin
        state_d = state_q;
        rc_d    = rc_q;
        step_d  = 1'b0;
        if (step_evt.rel) begin
            state_d = ST_IDLE;
            rc_d    = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (step_evt.press) begin
                        step_d  = 1'b1;
                        rc_d    = '0;
                        state_d = ST_DELAY;
                    end
                end
                ST_DELAY: begin
                    if (RPT_EN) begin
                        if (rc_q == DLY_END) begin
                            step_d  = 1'b1;
                            rc_d    = '0;
                            state_d = ST_REPEAT;
                        end else begin
                            rc_d = rc_q + 1'b1;
                        end
                    end
                end
                ST_REPEAT: begin
                    if (rc_q == RATE_END) begin
                        step_d = 1'b1;
                        rc_d   = '0;
                    end else begin
                        rc_d = rc_q + 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    rc_d    = '0;
                end
            endcase
        end
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            step_pulse <= 1'b0;
            dir_pulse  <= 1'b0;
            dir        <= 1'b0;
            step_held  <= 1'b0;
        end else begin
            step_pulse <= step_d;
            dir_pulse  <= dir_evt.press;
            step_held  <= ~step_evt.db;
            if (dir_evt.press) begin
                dir <= ~dir;
            end
        end
    end

endmodule
